imem_fetch_responder: RTL
=========================

// Module: imem_fetch_responder
// PURPOSE
//  Instruction-side responder for the five-stage cpu core. It holds a program
//  that a testbench or host loads word-serially. It answers the core's pc with
//  inst and a one-cycle pcEn strobe, inserting programmable wait states.
//  It drives NOP on inst whenever no instruction is issued, because the core's
//  IF/ID register captures inst on every clock. It sits between the loader and
//  the cpu's inst/pc/pcEn ports.
// PARAMETERS
//  DEPTH   256           program words held (power of 2, >=2)
//  ADDR_W  $clog2(DEPTH) word-address width
//  WAIT    1             extra wait cycles per fetch (0..15)
//  NOP     32'h0000_0000 value driven on inst when not issuing
// PORTS
//  clk       in   1   single clock, rising edge
//  reset_n   in   1   asynchronous, active-low reset
//  ld_valid  in   1   load word present
//  ld_ready  out  1   responder accepts load word
//  ld_data   in   32  program word, stored at next sequential address
//  ld_last   in   1   marks final program word (qualified by ld_valid&&ld_ready)
//  run       in   1   level: enable fetch service
//  pc        in   32  byte address from cpu
//  inst      out  32  instruction, valid only while pcEn=1, else NOP
//  pcEn      out  1   one-cycle strobe; cpu captures inst and advances pc
//  loaded    out  1   program present (count>0)
//  fault     out  1   sticky: misaligned or out-of-range pc
// BEHAVIOUR
//  Reset (async, any state): state=LOAD, wptr=0, count=0, ld_ready=1, pcEn=0,
//   inst=NOP, loaded=0, fault=0. Memory array is not cleared.
//  All outputs are registered. Memory is read synchronously.
//  States:
//  - LOAD: ld_ready=1. On ld_valid&&ld_ready: mem[wptr]<=ld_data, wptr++.
//    If ld_last or wptr==DEPTH-1: count<=wptr+1, go to READY, ld_ready<=0.
//  - READY: loaded=1, ld_ready=0, ld_valid ignored. When run=1, go to FETCH.
//  - FETCH: sample pc, load the wait counter with WAIT.
//    If pc[1:0]!=0 or pc[31:2]>=count: fault<=1, go to FAULT.
//    Else, if WAIT==0, go to ISSUE; otherwise go to WAIT_ST.
//  - WAIT_ST: decrement the counter; at 1, go to ISSUE. The sampled address is
//    held, so pc changes here are ignored.
//  - ISSUE: for exactly one cycle, pcEn=1 and inst=mem[addr].
//    Next state is FETCH if run=1, else READY.
//  - FAULT: pcEn=0, inst=NOP, fault=1. Only reset_n exits.
//  Timing: after FETCH is entered at cycle t, pcEn=1 in cycle t+WAIT+1.
//   The issue period is WAIT+2 cycles, and pcEn is never high two cycles in a row.
//   The cpu updates pc at the end of the ISSUE cycle, so the next FETCH sees the
//   new pc.
//  Core stall: if the cpu holds pc, the same word is reissued on the next strobe.
//   This is correct behaviour, not an error.
//  Branch/jump: any aligned in-range pc is served. There is no sequential
//   prediction.
//  run drop: the current fetch completes through ISSUE, then the block returns to
//   READY. While run=0, pcEn=0 and inst=NOP.
//  pc wider than the array: bits above ADDR_W+1 are checked against count only
//   (pc[31:2]>=count => fault). No wrap-around.
//  Simultaneous ld_last with wptr==DEPTH-1: a single transition, count=DEPTH.
//  Reset mid-operation: pcEn and inst drop asynchronously. The program must be
//   reloaded.
// TESTING
//  T1 load: load 0x20010005, 0x20020003, 0x00221820, 0xAC030000 with ld_last on
//     the 4th -> count=4, loaded=1, ld_ready=0. A 5th ld_valid is not accepted.
//  T2 run, WAIT=1, cpu model advances pc by 4 per strobe:
//     pcEn high 2 cycles after FETCH, every 3 cycles.
//     inst sequence 0x20010005, 0x20020003, 0x00221820, 0xAC030000.
//     inst=0 on all other cycles.
//  T3 faults: pc=0x0000_000E -> fault=1 and no strobe.
//     After reset and reload, pc=0x0000_0010 with count=4 -> fault=1.
//     Faults stay asserted until reset_n.
//  T4 stall/jump: hold pc=0x4 for two strobes -> 0x20020003 issued twice.
//     Then step pc to 0x0 -> 0x20010005.
//  T5 run drop and reset: drop run in WAIT_ST -> one final strobe, then READY,
//     pcEn=0. Assert reset_n=0 mid-ISSUE -> pcEn=0, inst=0, loaded=0, ld_ready=1
//     in the same cycle.
//  T6 capacity: DEPTH=8, stream 10 words without ld_last -> 8 accepted, count=8,
//     ld_ready=0 after the 8th.

Source files
------------

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: loads a program word-serially, then answers the
// core's pc with a registered inst and a one-cycle pcEn strobe after WAIT stall cycles.
module imem_fetch_responder #(
    parameter int          DEPTH  = 256,
    parameter int          ADDR_W = $clog2(DEPTH),
    parameter int          WAIT   = 1,
    parameter logic [31:0] NOP    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    input  logic        run,
    input  logic [31:0] pc,
    output logic [31:0] inst,
    output logic        pcEn,
    output logic        loaded,
    output logic        fault
);

    typedef enum logic [2:0] {
        LOAD,
        READY,
        FETCH,
        WAIT_ST,
        ISSUE,
        FAULT
    } state_t;

    localparam logic [3:0]        WAIT_CYC  = 4'(WAIT);
    localparam logic [ADDR_W-1:0] WPTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] WPTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

    logic [31:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic              ld_ready_q, ld_ready_d;
    logic              pcen_q, pcen_d;
    logic [31:0]       inst_q, inst_d;
    logic              loaded_q, loaded_d;
    logic              fault_q, fault_d;

    logic              mem_we;
    logic [ADDR_W-1:0] rd_addr;
    logic              pc_bad;

    // Bits above the array width are not ignored: any word index >= count faults.
    assign pc_bad = (pc[1:0] != 2'b00) || (pc[31:2] >= 30'(count_q));

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d = state_q;
        wptr_d  = wptr_q;
        addr_d  = addr_q;
        count_d = count_q;
        wcnt_d  = wcnt_q;
        fault_d = fault_q;
        mem_we  = 1'b0;
        rd_addr = addr_q;

        case (state_q)
            LOAD: begin
                if (ld_valid && ld_ready_q) begin
                    mem_we = 1'b1;
                    wptr_d = wptr_q + WPTR_ONE;
                    if (ld_last || (wptr_q == WPTR_LAST)) begin
                        count_d = {1'b0, wptr_q} + COUNT_ONE;
                        state_d = READY;
                    end
                end
            end
            READY: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                addr_d  = pc[ADDR_W+1:2];
                rd_addr = pc[ADDR_W+1:2];
                wcnt_d  = WAIT_CYC;
                if (pc_bad) begin
                    fault_d = 1'b1;
                    state_d = FAULT;
                end else if (WAIT_CYC == 4'd0) begin
                    state_d = ISSUE;
                end else begin
                    state_d = WAIT_ST;
                end
            end
            WAIT_ST: begin
                wcnt_d = wcnt_q - 4'd1;
                if (wcnt_q <= 4'd1) state_d = ISSUE;
            end
            ISSUE: begin
                state_d = run ? FETCH : READY;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: state_d = LOAD;
        endcase

        // Outputs are registered from the next state, so they line up with the state they describe.
        ld_ready_d = (state_d == LOAD);
        pcen_d     = (state_d == ISSUE);
        inst_d     = pcen_d ? mem[rd_addr] : NOP;
        loaded_d   = (count_d != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q    <= LOAD;
            wptr_q     <= '0;
            addr_q     <= '0;
            count_q    <= '0;
            wcnt_q     <= '0;
            ld_ready_q <= 1'b1;
            pcen_q     <= 1'b0;
            inst_q     <= NOP;
            loaded_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            wcnt_q     <= wcnt_d;
            ld_ready_q <= ld_ready_d;
            pcen_q     <= pcen_d;
            inst_q     <= inst_d;
            loaded_q   <= loaded_d;
            fault_q    <= fault_d;
        end
    end

    // NOTE: the program array has no reset; count gates every read, so stale contents are never issued.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wptr_q] <= ld_data;
    end

    assign ld_ready = ld_ready_q;
    assign pcEn     = pcen_q;
    assign inst     = inst_q;
    assign loaded   = loaded_q;
    assign fault    = fault_q;

endmodule
